// File: rtl/nn_pkg.sv
// Shared types and default sizing for the neuron-layer sequencer.
// Address widths are derived from depths via addr_w so a depth of 1 still gets a 1-bit bus.
package nn_pkg;

    localparam int IN_WIDTH_DEF    = 16;
    localparam int NUM_INPUTS_DEF  = 784;
    localparam int NUM_NEURONS_DEF = 10;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PIX_AW_DEF = addr_w(NUM_INPUTS_DEF);
    localparam int W_AW_DEF   = addr_w(NUM_INPUTS_DEF * NUM_NEURONS_DEF);
    localparam int N_AW_DEF   = addr_w(NUM_NEURONS_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_BIAS,
        S_STREAM,
        S_WAIT,
        S_WRITE
    } feeder_state_t;

endpackage

// File: rtl/beat_counter.sv
// Up-counter from 0 to MAX-1 with synchronous clear and a terminal-count flag.
// Advancing past the terminal count returns to 0 explicitly.
module beat_counter #(
    parameter int MAX = 4,
    parameter int CW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == CW'(MAX - 1));

endmodule

// File: rtl/neuron_feeder.sv
// Sequences one layer through a serial neuron: bias fetch, NUM_INPUTS pixel/weight beats,
// wait for the neuron result, then write it to the result memory at the neuron index.
module neuron_feeder
    import nn_pkg::*;
#(
    parameter int IN_WIDTH    = IN_WIDTH_DEF,
    parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int PIX_AW      = addr_w(NUM_INPUTS),
    parameter int W_AW        = addr_w(NUM_INPUTS * NUM_NEURONS),
    parameter int N_AW        = addr_w(NUM_NEURONS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [PIX_AW-1:0]   pix_addr,
    input  logic [IN_WIDTH-1:0] pix_rdata,
    output logic [W_AW-1:0]     w_addr,
    input  logic [IN_WIDTH-1:0] w_rdata,
    output logic [N_AW-1:0]     b_addr,
    input  logic [IN_WIDTH-1:0] b_rdata,
    output logic [IN_WIDTH-1:0] nrn_data,
    output logic [IN_WIDTH-1:0] nrn_weight,
    output logic [IN_WIDTH-1:0] nrn_bias,
    output logic                nrn_valid,
    input  logic [IN_WIDTH-1:0] nrn_out,
    input  logic                nrn_out_valid,
    output logic                res_we,
    output logic [N_AW-1:0]     res_addr,
    output logic [IN_WIDTH-1:0] res_data
);

    feeder_state_t       r_state;
    feeder_state_t       w_next;
    logic [PIX_AW-1:0]   w_i;
    logic [N_AW-1:0]     w_n;
    logic                w_i_tc;
    logic                w_n_tc;
    logic                w_start_acc;
    logic                w_stream;
    logic [W_AW-1:0]     r_wp;
    logic                r_nrn_valid;
    logic [IN_WIDTH-1:0] r_nrn_bias;
    logic [N_AW-1:0]     r_res_addr;
    logic [IN_WIDTH-1:0] r_res_data;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_stream    = (r_state == S_STREAM);

    beat_counter #(.MAX(NUM_INPUTS), .CW(PIX_AW)) u_beat (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start_acc),
        .i_en    (w_stream),
        .o_count (w_i),
        .o_tc    (w_i_tc)
    );

    beat_counter #(.MAX(NUM_NEURONS), .CW(N_AW)) u_neuron (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start_acc),
        .i_en    ((r_state == S_WRITE) && !w_n_tc),
        .o_count (w_n),
        .o_tc    (w_n_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next takes its default first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_LOAD_BIAS;
            S_LOAD_BIAS: w_next = S_STREAM;
            S_STREAM:    if (w_i_tc) w_next = S_WAIT;
            S_WAIT:      if (nrn_out_valid) w_next = S_WRITE;
            S_WRITE:     w_next = w_n_tc ? S_IDLE : S_LOAD_BIAS;
            default:     w_next = S_IDLE;
        endcase
    end

    // Running weight pointer; it holds on the very last beat of the layer so it never leaves the ROM.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_wp <= '0;
        end else if (w_stream && !(w_i_tc && w_n_tc)) begin
            r_wp <= r_wp + W_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nrn_valid <= 1'b0;
            r_nrn_bias  <= '0;
            r_res_addr  <= '0;
            r_res_data  <= '0;
        end else begin
            r_nrn_valid <= w_stream;
            if (w_stream && (w_i == '0)) begin
                r_nrn_bias <= b_rdata;
            end
            if ((r_state == S_WAIT) && nrn_out_valid) begin
                r_res_addr <= w_n;
                r_res_data <= nrn_out;
            end
        end
    end

    // ROM read data arrives one cycle after the issue, in step with the registered valid.
    assign nrn_data   = r_nrn_valid ? pix_rdata : '0;
    assign nrn_weight = r_nrn_valid ? w_rdata   : '0;
    assign nrn_valid  = r_nrn_valid;
    assign nrn_bias   = r_nrn_bias;

    assign pix_addr = w_i;
    assign w_addr   = r_wp;
    assign b_addr   = w_n;
    assign busy     = (r_state != S_IDLE);
    assign res_we   = (r_state == S_WRITE);
    assign done     = (r_state == S_WRITE) && w_n_tc;
    assign res_addr = r_res_addr;
    assign res_data = r_res_data;

endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
Sequencer that drives the serial input side of one `neuron` instance and collects its outputs.
- On `start`, it evaluates a layer of NUM_NEURONS neurons, one at a time.
- For each neuron it streams NUM_INPUTS pixel/weight pairs from synchronous-read memories and presents the bias.
- It waits for the neuron's `out_valid`, then writes the result into a result memory.
- It sits between the image/weight/bias ROMs and the neuron datapath. It is the producer/consumer counterpart of the neuron's `input_valid` / `out_valid` protocol.

Parameters:
- IN_WIDTH, 16, width of pixel, weight, bias and result words.
- NUM_INPUTS, 784, beats per neuron. Must match the neuron's NUM_INPUTS; minimum 2.
- NUM_NEURONS, 10, neurons per layer; minimum 1.
- PIX_AW, $clog2(NUM_INPUTS), pixel address width.
- W_AW, $clog2(NUM_INPUTS*NUM_NEURONS), weight address width.
- N_AW, $clog2(NUM_NEURONS) (min 1), bias/result address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset. Shared with the attached neuron.
- start  in  1  one-cycle request to evaluate the layer. Sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last result is written.
- pix_addr  out  PIX_AW  pixel memory address.
- pix_rdata  in  IN_WIDTH  pixel data, valid 1 cycle after address.
- w_addr  out  W_AW  weight memory address.
- w_rdata  in  IN_WIDTH  weight data, 1-cycle latency.
- b_addr  out  N_AW  bias memory address.
- b_rdata  in  IN_WIDTH  bias data, 1-cycle latency.
- nrn_data  out  IN_WIDTH  to neuron `data_in`.
- nrn_weight  out  IN_WIDTH  to neuron `weight_in`.
- nrn_bias  out  IN_WIDTH  to neuron `bias_in` (registered, held per neuron).
- nrn_valid  out  1  to neuron `input_valid`.
- nrn_out  in  IN_WIDTH  from neuron `data_out`.
- nrn_out_valid  in  1  from neuron `out_valid`.
- res_we  out  1  result write strobe.
- res_addr  out  N_AW  result address = neuron index.
- res_data  out  IN_WIDTH  result word.

Behaviour:
- Reset state:
  - All outputs are 0 and the FSM is IDLE.
  - The neuron, index counter n, beat counter i and weight pointer wp are cleared.
  - Reset mid-operation aborts immediately. No res_we or done follows. The neuron is cleared by the same rst.
- FSM states: IDLE, LOAD_BIAS, STREAM, WAIT, WRITE.
- IDLE:
  - `start` = 1 → LOAD_BIAS; set n = 0, wp = 0, busy = 1.
  - `start` in any other state is ignored.
- LOAD_BIAS (1 cycle): drive b_addr = n → STREAM.
- STREAM (NUM_INPUTS cycles):
  - On the first STREAM cycle, register nrn_bias <= b_rdata.
  - Each cycle drive pix_addr = i and w_addr = wp, then increment i and wp.
  - The weight address is a running pointer (neuron n, beat i → n*NUM_INPUTS + i). No multiplier.
  - After the issue with i = NUM_INPUTS-1 → WAIT, with i cleared.
- Data alignment:
  - nrn_valid, nrn_data and nrn_weight are registered from the issue qualifier and rdata, one cycle after each address issue.
  - nrn_valid is high for exactly NUM_INPUTS consecutive cycles per neuron, with no gaps.
  - nrn_valid is never high outside those beats.
  - nrn_bias is stable throughout, including the final beat where the neuron consumes it.
- WAIT:
  - The final beat's nrn_valid occurs in the first WAIT cycle.
  - On `nrn_out_valid` = 1, capture res_data <= nrn_out and res_addr <= n → WRITE.
  - `nrn_out_valid` seen in any other state is ignored.
- WRITE (1 cycle):
  - Assert res_we = 1.
  - If n == NUM_NEURONS-1: assert done = 1, busy <= 0 → IDLE.
  - Otherwise n <= n+1 → LOAD_BIAS.
- Latency:
  - With the standard 1-cycle neuron, one neuron period is NUM_INPUTS+4 cycles, from LOAD_BIAS to WRITE inclusive.
  - The first LOAD_BIAS is the cycle after start.
  - done occurs NUM_NEURONS*(NUM_INPUTS+4) cycles after the start cycle.
- Arithmetic: none on data. Counters wrap only by explicit clear; wp never exceeds NUM_INPUTS*NUM_NEURONS-1.

Decomposition:
- Shared package `nn_pkg`:
  - FSM state enum (feeder_state_t).
  - IN_WIDTH default.
  - The `$clog2`-based address-width helper constants.
- Sub-module: none required.
  - The optional natural split is `beat_counter`, a terminal-count counter with clear, used for i and n.
- The top-level integration instantiates `neuron_feeder` + `neuron` sharing clk/rst.

Test Plan:
All tests use NUM_INPUTS=4, NUM_NEURONS=2, the real neuron (OUT_SHIFT=15) and behavioural 1-cycle ROMs.
- Pixels all 0x4000, neuron-0 weights 0x1000, bias 0, start pulse → res_we with res_addr=0, res_data=0x2000; nrn_valid high exactly 4 consecutive cycles.
- Neuron-1 weights 0xF000, same pixels → res_addr=1, res_data=0x0000 (ReLU); done pulses once, in the same cycle as that res_we; done occurs 16 cycles after start.
- Pixels 0, bias[0]=0x0100 → res_data=0x2000 for neuron 0 becomes 0x0100; confirms bias is held stable at the final beat.
- w_addr trace over the full run = 0,1,2,3,4,5,6,7; pix_addr = 0,1,2,3 twice; b_addr = 0 then 1.
- start re-asserted while busy, and a spurious nrn_out_valid forced in STREAM → both ignored; results are unchanged.
- rst asserted in the 3rd STREAM cycle of neuron 0, then start again → no res_we/done before the restart; all outputs are 0 during rst; the rerun yields 0x2000 and 0x0000.
